pkts_fifo: RTL
==============

# pkts_fifo

Parametrised packet FIFO for `pkts_if` streams (`tdata`/`tlast`/`tvalid`/`tready`). It buffers beats between a producer (rx side) and a consumer (tx side), with configurable data width and depth. It runs in one of two modes: cut-through, or store-and-forward, where a packet is released only once its `tlast` beat is stored. It sits between any two `pkts_if` endpoints and also exposes fill level and stored-packet count for flow control and debug.

## Interface
Parameters:
- `WIDTH`, 32, `tdata` width in bits, ≥1
- `DEPTH`, 16, beat capacity; power of two, ≥2
- `MODE`, `PKTS_CUT_THROUGH`, `pkts_fifo_mode_t`; `PKTS_STORE_FWD` gates output on whole packets

Ports (`in_*` follow `pkts_if.rx`, `out_*` follow `pkts_if.tx`):
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  reset; synchronous, active-high
- `in_tdata`  in  WIDTH  input beat data
- `in_tlast`  in  1  last beat of input packet
- `in_tvalid`  in  1  input beat valid
- `in_tready`  out  1  FIFO accepts a beat
- `out_tdata`  out  WIDTH  head beat data
- `out_tlast`  out  1  head beat is last of its packet
- `out_tvalid`  out  1  head beat available
- `out_tready`  in  1  consumer accepts head beat
- `level`  out  $clog2(DEPTH+1)  beats stored
- `pkt_count`  out  $clog2(DEPTH+1)  complete packets stored (`tlast` written, not yet popped)

## Operation
- Push when `in_tvalid && in_tready`. Pop when `out_tvalid && out_tready`.
- `in_tready = !rst && level != DEPTH`. It does not depend on `out_tready`, so a full FIFO with a simultaneous pop still refuses the push in that cycle.
- Storage is a DEPTH×(WIDTH+1) register array holding `{tlast, tdata}`.
- `wr_ptr` and `rd_ptr` are `$clog2(DEPTH)` bits and wrap naturally from DEPTH-1 to 0.
- `level` counts pushes minus pops; simultaneous push and pop leaves it unchanged.
- `pkt_count` increments on a push with `in_tlast=1` and decrements on a pop with `out_tlast=1`; simultaneous inc and dec leaves it unchanged.
- Output gating:
  - Cut-through: `out_tvalid = level != 0`.
  - Store-and-forward: `out_tvalid = level != 0 && (pkt_count != 0 || level == DEPTH || draining)`.
  - `draining` is a flag. It sets when `level == DEPTH && pkt_count == 0`, which is the oversize-packet deadlock escape. It clears on a pop of a `tlast` beat.
  - A partial packet is never otherwise exposed in store-and-forward mode.
- `out_tdata`/`out_tlast` = array[`rd_ptr`]. They are held stable while `out_tvalid && !out_tready`, and are don't-care while `out_tvalid=0`.
- Packet boundaries are preserved exactly; beats are never dropped, reordered or merged.
- No input-to-output combinational path: `out_*` and `in_tready` derive only from registers and `rst`.

## Timing
- Reset (sync): `wr_ptr`, `rd_ptr`, `level`, `pkt_count` and `draining` go to 0.
  - While `rst=1`: `out_tvalid=0` and `in_tready=0`.
  - First cycle after `rst` falls: `in_tready=1`.
  - Array contents are not reset.
- Reset mid-operation: all stored beats are discarded within the reset cycle. Pushes and pops presented in that cycle are ignored.
- Latency:
  - Cut-through: beat pushed at edge N is visible on `out_*` in cycle N+1.
  - Store-and-forward: the first beat of a packet is visible in the cycle after its `tlast` beat is pushed.
- Full-rate throughput: one beat per cycle with continuous push and pop when not full.
- Empty with push: no bypass; `out_tvalid` rises the next cycle.

## Structure
- `pkts_pkg` holds `typedef enum logic {PKTS_CUT_THROUGH, PKTS_STORE_FWD} pkts_fifo_mode_t`. It is shared with future `pkts_*` blocks.
- Sub-module `pkts_fifo_mem`:
  - Parameters WIDTH+1 and DEPTH.
  - Write port: `we`, `waddr`, `wdata`.
  - Asynchronous read of `raddr`.
- Top-level `pkts_fifo` owns the pointers, counters, gating logic and `draining`.

## Test plan
- Cut-through, DEPTH=4, `out_tready=1`: push beats 0xA0..0xA2 (`tlast` on 0xA2) back-to-back -> each appears one cycle after its push; `level` never exceeds 1.
- Fill to full, DEPTH=4, `out_tready=0`: push 5 beats -> `in_tready=0` after the 4th; `level=4`; 5th beat held by the source and accepted one cycle after the first pop.
- Store-and-forward, DEPTH=8: 3-beat packet with one idle cycle per beat -> `out_tvalid` stays 0 until the cycle after the `tlast` push; then 3 beats drain with `pkt_count` going 1→0 on the final pop.
- Store-and-forward oversize, DEPTH=4: push a 6-beat packet -> at `level=4, pkt_count=0`, `draining` sets and output flows; all 6 beats arrive in order with `tlast` on the 6th; `draining` clears.
- Wrap and simultaneous push/pop, DEPTH=4: 20 single-beat packets with random `out_tready` -> data order intact, `level`/`pkt_count` match the scoreboard every cycle.
- Mid-stream reset: `rst` for 1 cycle with `level=3` -> next cycle `level=0`, `pkt_count=0`, `out_tvalid=0`, `in_tready=1`.

Source files
------------

// File: rtl/pkts_pkg.sv
// Shared definitions for the pkts_* stream blocks.
package pkts_pkg;

    // FIFO output policy: expose beats as soon as stored, or only whole packets.
    typedef enum logic {
        PKTS_CUT_THROUGH,
        PKTS_STORE_FWD
    } pkts_fifo_mode_t;

endpackage

// File: rtl/pkts_fifo_mem.sv
// Beat storage for pkts_fifo: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset; occupancy is tracked by the owner.
module pkts_fifo_mem #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Store the incoming beat at the write pointer.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pkts_fifo.sv
// Packet FIFO between two pkts_if endpoints. Supports cut-through and
// store-and-forward release, and reports fill level and complete-packet count.
// All outputs derive from registers and rst only (no in->out combinational path).
module pkts_fifo
    import pkts_pkg::*;
#(
    parameter int              WIDTH = 32,
    parameter int              DEPTH = 16,
    parameter pkts_fifo_mode_t MODE  = PKTS_CUT_THROUGH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           in_tdata,
    input  logic                       in_tlast,
    input  logic                       in_tvalid,
    output logic                       in_tready,
    output logic [WIDTH-1:0]           out_tdata,
    output logic                       out_tlast,
    output logic                       out_tvalid,
    input  logic                       out_tready,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic [$clog2(DEPTH+1)-1:0] pkt_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          draining;
    logic          full;
    logic          push;
    logic          pop;
    logic          pkt_inc;
    logic          pkt_dec;
    logic [WIDTH:0] head;

    // Readiness ignores out_tready on purpose: a full FIFO refuses even if popping.
    assign full      = (level == LW'(DEPTH));
    assign in_tready = !rst && !full;
    assign push      = in_tvalid && in_tready;
    assign pop       = out_tvalid && out_tready;
    assign pkt_inc   = push && in_tlast;
    assign pkt_dec   = pop && out_tlast;

    pkts_fifo_mem #(
        .WIDTH (WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata ({in_tlast, in_tdata}),
        .raddr (rd_ptr),
        .rdata (head)
    );

    assign {out_tlast, out_tdata} = head;

    // Release policy: store-and-forward waits for a whole packet unless a
    // packet larger than the FIFO would otherwise deadlock (full or draining).
    always_comb begin
        out_tvalid = 1'b0;
        if (!rst && level != '0) begin
            if (MODE == PKTS_STORE_FWD) begin
                out_tvalid = (pkt_count != '0) || full || draining;
            end else begin
                out_tvalid = 1'b1;
            end
        end
    end

    // Pointers, occupancy counters and the oversize-packet drain flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            pkt_count <= '0;
            draining  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: ;
            endcase
            case ({pkt_inc, pkt_dec})
                2'b10:   pkt_count <= pkt_count + LW'(1);
                2'b01:   pkt_count <= pkt_count - LW'(1);
                default: ;
            endcase
            // Full with no complete packet: let the head packet stream out
            // until its tlast leaves.
            if (pkt_dec) begin
                draining <= 1'b0;
            end else if (full && pkt_count == '0) begin
                draining <= 1'b1;
            end
        end
    end

endmodule
